// File: rtl/shift_reg_univ_if.sv
// Mode/data/status bundle for the universal shift register.
// The controller drives the mode and data lines; the register returns its contents and the flags derived from them.
interface shift_reg_univ_if #(
    parameter int unsigned N = 4
);
    logic [2:0]   M;
    logic         DF;
    logic         DB;
    logic [N-1:0] P;
    logic [N-1:0] Q;
    logic [N-1:0] NQ;
    logic         SOF;
    logic         SOB;
    logic         Z;

    modport master (
        output M, DF, DB, P,
        input  Q, NQ, SOF, SOB, Z
    );

    modport slave (
        input  M, DF, DB, P,
        output Q, NQ, SOF, SOB, Z
    );
endinterface

// File: rtl/shift_reg_univ.sv
// N-bit universal shift register. A 3-bit mode code selects one of these operations:
// hold, forward or backward shift, parallel load, forward or backward rotate, or synchronous clear.
// R is an asynchronous clear. Q[0] is stage 0, and forward shifts move data toward Q[N-1].
module shift_reg_univ #(
    parameter int unsigned N = 4
) (
    input logic              C,
    input logic              R,
    shift_reg_univ_if.slave  bus
);
    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_FWD   = 3'b001,
        MODE_BWD   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROTF  = 3'b100,
        MODE_ROTB  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    mode_e        mode;
    logic [N-1:0] q;
    logic [N-1:0] q_next;

    assign mode = mode_e'(bus.M);

    // Next contents, computed entirely from the pre-edge value of q so every stage moves together.
    always_comb begin
        q_next = q;
        case (mode)
            MODE_FWD:   q_next = {q[N-2:0], bus.DF};
            MODE_BWD:   q_next = {bus.DB, q[N-1:1]};
            MODE_LOAD:  q_next = bus.P;
            MODE_ROTF:  q_next = {q[N-2:0], q[N-1]};
            MODE_ROTB:  q_next = {q[0], q[N-1:1]};
            MODE_CLEAR: q_next = '0;
            default:    q_next = q;
        endcase
    end

    // Storage stages. R clears them at once and overrides any clock edge while it is high.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    assign bus.Q   = q;
    assign bus.NQ  = ~q;
    assign bus.SOF = q[N-1];
    assign bus.SOB = q[0];
    assign bus.Z   = (q == '0);
endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ.
// It uses one N=4 instance and a cascade of two N=2 instances chained SOF->DF.
module tb_shift_reg_univ;
    logic C;
    logic R;

    shift_reg_univ_if #(.N(4)) sif ();
    shift_reg_univ_if #(.N(2)) cif_a ();
    shift_reg_univ_if #(.N(2)) cif_b ();

    shift_reg_univ #(.N(4)) dut (.C(C), .R(R), .bus(sif));
    shift_reg_univ #(.N(2)) dut_a (.C(C), .R(R), .bus(cif_a));
    shift_reg_univ #(.N(2)) dut_b (.C(C), .R(R), .bus(cif_b));

    assign cif_b.DF = cif_a.SOF;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Wait for a rising edge, then settle 2 time units so sampling and driving stay clear of the edge.
    task automatic tick();
        @(posedge C);
        #2;
    endtask

    task automatic load4(input logic [3:0] v);
        sif.M = 3'b011;
        sif.P = v;
        tick();
        check("load", 32'(sif.Q), 32'(v));
    endtask

    logic [3:0] exp_seq [4];
    logic [3:0] casc;

    initial begin
        R = 1'b1;
        sif.M = 3'b000; sif.DF = 1'b0; sif.DB = 1'b0; sif.P = '0;
        cif_a.M = 3'b000; cif_a.DF = 1'b0; cif_a.DB = 1'b0; cif_a.P = '0;
        cif_b.M = 3'b000; cif_b.DB = 1'b0; cif_b.P = '0;
        #3;
        check("rst_q", 32'(sif.Q), 32'h0);
        check("rst_nq", 32'(sif.NQ), 32'hF);
        check("rst_z", 32'(sif.Z), 32'h1);
        check("rst_sof", 32'(sif.SOF), 32'h0);
        check("rst_sob", 32'(sif.SOB), 32'h0);
        tick();
        R = 1'b0;

        // asynchronous reset between edges
        load4(4'b1011);
        R = 1'b1;
        #1;
        check("async_rst_q", 32'(sif.Q), 32'h0);
        check("async_rst_z", 32'(sif.Z), 32'h1);
        sif.M = 3'b011; sif.P = 4'b1111;
        tick();
        check("rst_edge_ignored", 32'(sif.Q), 32'h0);
        tick();
        check("rst_edge_ignored2", 32'(sif.Q), 32'h0);
        R = 1'b0;

        // forward shift
        exp_seq = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        sif.M = 3'b001;
        foreach (exp_seq[i]) begin
            sif.DF = (i == 1) ? 1'b0 : 1'b1;
            tick();
            check("fwd", 32'(sif.Q), 32'(exp_seq[i]));
        end
        check("fwd_sof", 32'(sif.SOF), 32'h1);

        // backward shift
        load4(4'b1000);
        exp_seq = '{4'b0100, 4'b0010, 4'b0001, 4'b0001};
        sif.M = 3'b010; sif.DB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bwd", 32'(sif.Q), 32'(exp_seq[i]));
        end
        check("bwd_sob", 32'(sif.SOB), 32'h1);

        // rotate forward, then rotate backward, with the serial inputs held high to show they are ignored
        load4(4'b1001);
        sif.DF = 1'b1; sif.DB = 1'b1;
        exp_seq = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
        sif.M = 3'b100;
        foreach (exp_seq[i]) begin
            tick();
            check("rotf", 32'(sif.Q), 32'(exp_seq[i]));
        end
        exp_seq = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
        sif.M = 3'b101;
        foreach (exp_seq[i]) begin
            tick();
            check("rotb", 32'(sif.Q), 32'(exp_seq[i]));
        end

        // hold, reserved, clear
        load4(4'b0110);
        sif.M = 3'b000; sif.DF = 1'b1; sif.DB = 1'b1; sif.P = 4'b1111;
        tick();
        check("hold", 32'(sif.Q), 32'h6);
        sif.M = 3'b111; sif.DF = 1'b0; sif.DB = 1'b0; sif.P = 4'b0000;
        tick();
        check("reserved", 32'(sif.Q), 32'h6);
        check("z_nonzero", 32'(sif.Z), 32'h0);
        sif.M = 3'b110; sif.P = 4'b1111;
        tick();
        check("clear_q", 32'(sif.Q), 32'h0);
        check("clear_z", 32'(sif.Z), 32'h1);

        // cascade of two N=2 instances against a single N=4 instance, plus a mid-edge DF toggle
        exp_seq = '{4'b0001, 4'b0011, 4'b0110, 4'b1100};
        sif.M = 3'b001; cif_a.M = 3'b001; cif_b.M = 3'b001;
        foreach (exp_seq[i]) begin
            sif.DF   = (i < 2) ? 1'b1 : 1'b0;
            cif_a.DF = sif.DF;
            tick();
            casc = {cif_b.Q, cif_a.Q};
            check("casc", 32'(casc), 32'(exp_seq[i]));
            check("single", 32'(sif.Q), 32'(exp_seq[i]));
            if (i == 0) check("fill_z", 32'(sif.Z), 32'h0);
            // C is still high here, so toggling DF must not disturb Q
            sif.DF = ~sif.DF; cif_a.DF = ~cif_a.DF;
            #1;
            check("midhigh_single", 32'(sif.Q), 32'(exp_seq[i]));
            casc = {cif_b.Q, cif_a.Q};
            check("midhigh_casc", 32'(casc), 32'(exp_seq[i]));
        end
        sif.M = 3'b000; cif_a.M = 3'b000; cif_b.M = 3'b000;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
